// File: rtl/result_writer.sv
// Writes fixed-size result records into a ring of memory slots, one write-master
// transaction per record. Define RESULT_WRITER_TAG_EN to prefix a tag word.
module result_writer #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH = 32,
    parameter int NWORDS = 4,
    parameter int NSLOTS = 16,
    parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR = '0,
    localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic rec_valid,
    input  logic [NWORDS*DATAWIDTH-1:0] rec_data,
    output logic rec_ready,
    output logic write_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0] write_control_write_base,
    output logic [ADDRESSWIDTH-1:0] write_control_write_length,
    output logic write_control_go,
    input  logic write_control_done,
    output logic write_user_write_buffer,
    output logic [DATAWIDTH-1:0] write_user_buffer_data,
    input  logic write_user_buffer_full,
    output logic busy,
    output logic [15:0] rec_count,
    output logic [SW-1:0] slot
);

`ifdef RESULT_WRITER_TAG_EN
    localparam int TAGW = 1;
`else
    localparam int TAGW = 0;
`endif
    localparam int NTOT = NWORDS + TAGW;
    localparam int IW = $clog2(NTOT + 1);
    localparam logic [ADDRESSWIDTH-1:0] STRIDE =
        ADDRESSWIDTH'(NTOT * (DATAWIDTH / 8));
    localparam logic [IW-1:0] LAST = IW'(NTOT - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(NSLOTS - 1);

    typedef enum logic [1:0] {IDLE, GO, FILL, WAIT_DONE} state_t;

    state_t state_q, state_d;
    logic [NWORDS*DATAWIDTH-1:0] hold_q, hold_d;
    logic [ADDRESSWIDTH-1:0] base_q, base_d;
    logic [ADDRESSWIDTH-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic seen_q, seen_d;
    logic [15:0] cnt_q, cnt_d;
    logic [SW-1:0] slot_q, slot_d;
    logic go_q, go_d;
    logic busy_q, busy_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [DATAWIDTH-1:0] sel;
    logic [DATAWIDTH-1:0] words [NTOT];

    // Word 0 is the tag when enabled; payload words follow in order.
`ifdef RESULT_WRITER_TAG_EN
    assign words[0] = DATAWIDTH'({16'h5A5A, cnt_q});
`endif
    for (genvar g = 0; g < NWORDS; g++) begin : g_words
        assign words[g + TAGW] = hold_q[g*DATAWIDTH +: DATAWIDTH];
    end

    always_comb begin
        state_d = state_q;
        hold_d = hold_q;
        base_d = base_q;
        len_d = len_q;
        idx_d = idx_q;
        seen_d = seen_q;
        cnt_d = cnt_q;
        slot_d = slot_q;
        go_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rec_valid) begin
                    hold_d = rec_data;
                    base_d = BASE_ADDR + ADDRESSWIDTH'(slot_q) * STRIDE;
                    len_d = STRIDE;
                    go_d = 1'b1;
                    state_d = GO;
                end
            end
            GO: begin
                idx_d = '0;
                seen_d = 1'b0;
                state_d = FILL;
            end
            FILL: begin
                if (!write_control_done) seen_d = 1'b1;
                if (!write_user_buffer_full) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == LAST) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // done may still be high from the previous transfer
                if (!write_control_done) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    cnt_d = cnt_q + 16'd1;
                    slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Data register presents the word the next FILL cycle will push.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NTOT; i++) begin
            if (idx_d == IW'(i)) sel = words[i];
        end
        data_d = (state_d == FILL) ? sel : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q <= '0;
            base_q <= BASE_ADDR;
            len_q <= STRIDE;
            idx_q <= '0;
            seen_q <= 1'b0;
            cnt_q <= '0;
            slot_q <= '0;
            go_q <= 1'b0;
            busy_q <= 1'b0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            base_q <= base_d;
            len_q <= len_d;
            idx_q <= idx_d;
            seen_q <= seen_d;
            cnt_q <= cnt_d;
            slot_q <= slot_d;
            go_q <= go_d;
            busy_q <= busy_d;
            data_q <= data_d;
        end
    end

    assign rec_ready = (state_q == IDLE);
    assign write_user_write_buffer = (state_q == FILL) && !write_user_buffer_full;
    assign write_control_fixed_location = 1'b0;
    assign write_control_write_base = base_q;
    assign write_control_write_length = len_q;
    assign write_control_go = go_q;
    assign write_user_buffer_data = data_q;
    assign busy = busy_q;
    assign rec_count = cnt_q;
    assign slot = slot_q;

endmodule
